grid_controller: RTL and testbench
==================================

GRID_CONTROLLER -- requirements
Module: grid_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock  in  1 -- system clock; all state changes on rising edge.
- reset  in  1 -- asynchronous, active-high.
- init_start  in  1 -- request to initialise the level grid; sampled only in IDLE.
- init_done  out  1 -- one-cycle pulse when initialisation completes.
- busy  out  1 -- high while initialisation is in progress.
- grid_x  in  6 -- client column, 0..63.
- grid_y  in  5 -- client row, 0..31.
- grid_write  in  1 -- client write enable.
- grid_in  in  3 -- client write data.
- grid_out  out  3 -- registered read data.
- enemy_count  out  12 -- number of cells currently holding the enemy code.
REQ-003 Cell codes SHALL be: 0 = empty, 1 = wall, 4 = enemy; other codes are stored verbatim.

Function
REQ-004 Storage SHALL be 2048 cells of 3 bits, addressed as {grid_y, grid_x} (x least significant).
REQ-005 Client read:
- In IDLE, grid_out SHALL equal the cell at the address sampled on the previous rising edge (1-cycle latency).
- Read-during-write to the same address SHALL return the old value.
REQ-006 Client write: in IDLE, grid_write=1 at an edge SHALL store grid_in at the addressed cell on that edge.
REQ-007 enemy_count SHALL update on the same edge as each IDLE write:
- +1 when the old value != 4 and the new value == 4.
- -1 when the old value == 4 and the new value != 4.
- Unchanged otherwise, including a rewrite of 4 over 4.
REQ-008 FSM states SHALL be IDLE, CLEAR and DONE.
- IDLE to CLEAR on an edge with init_start=1; the 11-bit cell counter loads 0.
REQ-009 CLEAR SHALL write one cell per cycle, at the counter address, then increment the counter.
- Value 1 if x==0, x==63, y==0 or y==31; otherwise 0.
REQ-010 CLEAR to DONE SHALL occur on the edge that writes counter value 2047; the counter wraps to 0 and is not reused.
REQ-011 DONE SHALL assert init_done for exactly one cycle, force enemy_count to 0, and return to IDLE on the next edge.
REQ-012 busy SHALL be 1 in CLEAR and DONE and 0 in IDLE.
REQ-013 While busy, the block SHALL ignore grid_write and init_start, hold grid_out at 0 and leave enemy_count unchanged except as REQ-011 requires.
REQ-014 Simultaneous events in IDLE:
- If init_start and grid_write are both 1 on one edge, the write SHALL be performed (count updated) and CLEAR SHALL be entered.
- The init sequence then overwrites the written cell.
REQ-015 Latency: with init_start sampled at edge E0, cell writes SHALL occur at edges E1..E2048, init_done SHALL be high between E2048 and E2049, and IDLE SHALL resume at E2049.

Reset
REQ-016 Reset SHALL set state=IDLE, counter=0, grid_out=0, init_done=0, busy=0 and enemy_count=0, asynchronously at any time, including mid-CLEAR.
REQ-017 Cell storage SHALL NOT be reset; contents are undefined until one init sequence completes, and users SHALL run init after every reset.

Verification
REQ-018 Scenario 1 (init): reset, pulse init_start.
- busy SHALL be high for 2049 cycles and init_done high for exactly 1 cycle.
- Reads SHALL then return (0,0)=1, (63,31)=1, (0,15)=1, (5,7)=0, (62,30)=0.
REQ-019 Scenario 2 (read latency): after init, present (10,10), then (0,0) on consecutive cycles.
- grid_out SHALL be 0 then 1, each one cycle after its address.
REQ-020 Scenario 3 (enemy count): after init, perform these writes:
- 4 to (3,3): enemy_count=1.
- 4 to (3,3) again: enemy_count=1.
- 4 to (4,3): enemy_count=2.
- 0 to (3,3): enemy_count=1.
- 1 to (4,3): enemy_count=0.
REQ-021 Scenario 4 (busy lockout): during CLEAR, assert grid_write with 4 to (5,5) and pulse init_start.
- grid_out SHALL stay 0 and there SHALL be no restart; exactly one init_done SHALL occur.
- After completion, (5,5) SHALL read 0 and enemy_count=0.
REQ-022 Scenario 5 (reset mid-init): assert reset 100 cycles into CLEAR.
- busy=0, init_done=0, grid_out=0 and enemy_count=0 SHALL hold immediately.
- A fresh init_start SHALL complete normally with results matching Scenario 1.
REQ-023 Scenario 6 (simultaneous): in IDLE, assert grid_write with 4 to (2,2) and init_start on the same edge.
- enemy_count SHALL read 1 during CLEAR and 0 after DONE.
- (2,2) SHALL read 0.

Source files
------------

// File: rtl/grid_controller.sv
// Level-grid controller: 64x32 array of 3-bit cells with a client read/write port,
// a one-shot init sequence that paints a wall border, and a live enemy counter.
module grid_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        init_start,
    output logic        init_done,
    output logic        busy,
    input  logic [5:0]  grid_x,
    input  logic [4:0]  grid_y,
    input  logic        grid_write,
    input  logic [2:0]  grid_in,
    output logic [2:0]  grid_out,
    output logic [11:0] enemy_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [2:0] CELL_EMPTY = 3'd0;
    localparam logic [2:0] CELL_WALL  = 3'd1;
    localparam logic [2:0] CELL_ENEMY = 3'd4;

    localparam logic [10:0] LAST_CELL = 11'd2047;

    logic [1:0]  state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [2:0]  grid_out_q, grid_out_d;
    logic [11:0] enemy_q, enemy_d;

    logic [2:0]  mem [0:2047];

    logic [10:0] client_addr;
    logic [2:0]  old_val;
    logic        border;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [2:0]  mem_data;

    assign client_addr = {grid_y, grid_x};
    assign old_val     = mem[client_addr];
    assign border      = (cnt_q[5:0] == 6'd0) || (cnt_q[5:0] == 6'd63) ||
                         (cnt_q[10:6] == 5'd0) || (cnt_q[10:6] == 5'd31);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        enemy_d  = enemy_q;
        mem_we   = 1'b0;
        mem_addr = client_addr;
        mem_data = grid_in;
        case (state_q)
            IDLE: begin
                // A write and an init request on the same edge are both honoured.
                if (grid_write) begin
                    mem_we = 1'b1;
                    if ((old_val != CELL_ENEMY) && (grid_in == CELL_ENEMY)) begin
                        enemy_d = enemy_q + 12'd1;
                    end else if ((old_val == CELL_ENEMY) && (grid_in != CELL_ENEMY)) begin
                        enemy_d = enemy_q - 12'd1;
                    end
                end
                if (init_start) begin
                    state_d = CLEAR;
                    cnt_d   = 11'd0;
                end
            end
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = cnt_q;
                mem_data = border ? CELL_WALL : CELL_EMPTY;
                cnt_d    = cnt_q + 11'd1;
                if (cnt_q == LAST_CELL) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                enemy_d = 12'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Output is held at 0 whenever the next cycle is not an IDLE cycle.
        grid_out_d = (state_d == IDLE) ? old_val : CELL_EMPTY;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 11'd0;
            grid_out_q <= CELL_EMPTY;
            enemy_q    <= 12'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grid_out_q <= grid_out_d;
            enemy_q    <= enemy_d;
        end
    end

    // Cell storage has no reset; an init sequence defines its contents.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    assign grid_out    = grid_out_q;
    assign enemy_count = enemy_q;
    assign busy        = (state_q != IDLE);
    assign init_done   = (state_q == DONE);

endmodule

// File: tb/tb_grid_controller.sv
// Directed bench for grid_controller: init, read latency, enemy counting, busy lockout,
// reset during init and simultaneous write/init; read results go through a scoreboard queue.
module tb_grid_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        init_start = 1'b0;
    logic        init_done;
    logic        busy;
    logic [5:0]  grid_x = '0;
    logic [4:0]  grid_y = '0;
    logic        grid_write = 1'b0;
    logic [2:0]  grid_in = '0;
    logic [2:0]  grid_out;
    logic [11:0] enemy_count;

    int testCount = 0;
    int failCount = 0;
    logic [11:0] expQ [$];

    grid_controller dut (
        .clock       (clock),
        .reset       (reset),
        .init_start  (init_start),
        .init_done   (init_done),
        .busy        (busy),
        .grid_x      (grid_x),
        .grid_y      (grid_y),
        .grid_write  (grid_write),
        .grid_in     (grid_in),
        .grid_out    (grid_out),
        .enemy_count (enemy_count)
    );

    always #5 clock = ~clock;

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] x, input logic [4:0] y,
                                 input logic wr, input logic [2:0] d, input logic st);
        grid_x     = x;
        grid_y     = y;
        grid_write = wr;
        grid_in    = d;
        init_start = st;
    endtask

    task automatic checkOutput(input string tag, input logic [11:0] observed,
                               input logic [11:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic readCell(input string tag, input logic [5:0] x, input logic [4:0] y,
                            input logic [2:0] expVal);
        applyStimulus(x, y, 1'b0, 3'd0, 1'b0);
        expQ.push_back({9'd0, expVal});
        cycle();
        checkOutput(tag, {9'd0, grid_out}, expQ.pop_front());
    endtask

    // Write a cell; grid_out must show the pre-write value one cycle later.
    task automatic writeCell(input logic [5:0] x, input logic [4:0] y, input logic [2:0] d,
                             input logic [2:0] expOld, input logic [11:0] expEnemy);
        applyStimulus(x, y, 1'b1, d, 1'b0);
        expQ.push_back({9'd0, expOld});
        cycle();
        applyStimulus(x, y, 1'b0, 3'd0, 1'b0);
        checkOutput("wr_enemy_count", enemy_count, expEnemy);
        checkOutput("rdw_old_value", {9'd0, grid_out}, expQ.pop_front());
    endtask

    task automatic runInit(input logic wr, input logic [5:0] x, input logic [4:0] y,
                           input logic [2:0] d, input int lockAt, input int midAt,
                           input logic [11:0] midExp);
        int busyCycles = 0;
        int doneCycles = 0;
        logic outNonZero = 1'b0;
        applyStimulus(x, y, wr, d, 1'b1);
        cycle();
        applyStimulus(6'd0, 5'd0, 1'b0, 3'd0, 1'b0);
        while (busy === 1'b1 && busyCycles < 3000) begin
            busyCycles++;
            if (init_done === 1'b1) doneCycles++;
            if (grid_out !== 3'd0) outNonZero = 1'b1;
            if (busyCycles == midAt) checkOutput("enemy_mid_clear", enemy_count, midExp);
            if (busyCycles == lockAt) applyStimulus(6'd5, 5'd5, 1'b1, 3'd4, 1'b1);
            if (busyCycles == lockAt + 2) applyStimulus(6'd0, 5'd0, 1'b0, 3'd0, 1'b0);
            cycle();
        end
        checkOutput("busy_cycles", busyCycles[11:0], 12'd2049);
        checkOutput("init_done_pulses", doneCycles[11:0], 12'd1);
        checkOutput("grid_out_zero_busy", {11'd0, outNonZero}, 12'd0);
        checkOutput("enemy_after_init", enemy_count, 12'd0);
    endtask

    task automatic checkInitGrid();
        readCell("rd_0_0", 6'd0, 5'd0, 3'd1);
        readCell("rd_63_31", 6'd63, 5'd31, 3'd1);
        readCell("rd_0_15", 6'd0, 5'd15, 3'd1);
        readCell("rd_5_7", 6'd5, 5'd7, 3'd0);
        readCell("rd_62_30", 6'd62, 5'd30, 3'd0);
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_busy", {11'd0, busy}, 12'd0);
        checkOutput("rst_init_done", {11'd0, init_done}, 12'd0);
        checkOutput("rst_grid_out", {9'd0, grid_out}, 12'd0);
        checkOutput("rst_enemy", enemy_count, 12'd0);
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Scenario 1: init
        runInit(1'b0, 6'd0, 5'd0, 3'd0, -10, -10, 12'd0);
        checkInitGrid();

        // Scenario 2: read latency on consecutive cycles
        readCell("lat_10_10", 6'd10, 5'd10, 3'd0);
        readCell("lat_0_0", 6'd0, 5'd0, 3'd1);

        // Scenario 3: enemy counting
        writeCell(6'd3, 5'd3, 3'd4, 3'd0, 12'd1);
        writeCell(6'd3, 5'd3, 3'd4, 3'd4, 12'd1);
        writeCell(6'd4, 5'd3, 3'd4, 3'd0, 12'd2);
        writeCell(6'd3, 5'd3, 3'd0, 3'd4, 12'd1);
        writeCell(6'd4, 5'd3, 3'd1, 3'd4, 12'd0);
        readCell("rd_3_3", 6'd3, 5'd3, 3'd0);
        readCell("rd_4_3", 6'd4, 5'd3, 3'd1);

        // Scenario 4: writes and init requests ignored while busy
        runInit(1'b0, 6'd0, 5'd0, 3'd0, 50, -10, 12'd0);
        readCell("lock_5_5", 6'd5, 5'd5, 3'd0);
        checkOutput("lock_enemy", enemy_count, 12'd0);

        // Scenario 5: async reset 100 cycles into CLEAR, with an enemy counted at entry
        applyStimulus(6'd9, 5'd9, 1'b1, 3'd4, 1'b1);
        cycle();
        applyStimulus(6'd0, 5'd0, 1'b0, 3'd0, 1'b0);
        repeat (100) cycle();
        checkOutput("mid_busy", {11'd0, busy}, 12'd1);
        checkOutput("mid_enemy", enemy_count, 12'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_busy", {11'd0, busy}, 12'd0);
        checkOutput("arst_init_done", {11'd0, init_done}, 12'd0);
        checkOutput("arst_grid_out", {9'd0, grid_out}, 12'd0);
        checkOutput("arst_enemy", enemy_count, 12'd0);
        cycle();
        reset = 1'b0;
        cycle();
        runInit(1'b0, 6'd0, 5'd0, 3'd0, -10, -10, 12'd0);
        checkInitGrid();

        // Scenario 6: write and init on the same edge
        runInit(1'b1, 6'd2, 5'd2, 3'd4, -10, 10, 12'd1);
        readCell("sim_2_2", 6'd2, 5'd2, 3'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
